// File: rtl/conv_trellis_encoder_if.sv
// Streaming side of the convolutional/trellis encoder: input bit stream plus
// the two output streams (codewords and trellis-table entries).
interface conv_trellis_encoder_if #(
    parameter int MAX_K      = 9,
    parameter int MAX_R      = 3,
    parameter int RADIX_LOG2 = 2
);
    localparam int EW = RADIX_LOG2 + 2 * (MAX_K - 1) + RADIX_LOG2 * MAX_R;

    logic             i_bit_valid;
    logic             i_bit;
    logic             i_bit_last;
    logic             o_bit_ready;
    logic             o_enc_valid;
    logic [MAX_R-1:0] o_enc_data;
    logic             i_out_ready;
    logic             o_tbl_valid;
    logic [EW-1:0]    o_tbl_entry;

    // master = upstream/downstream environment, slave = the encoder itself
    modport master (
        output i_bit_valid, i_bit, i_bit_last, i_out_ready,
        input  o_bit_ready, o_enc_valid, o_enc_data, o_tbl_valid, o_tbl_entry
    );

    modport slave (
        input  i_bit_valid, i_bit, i_bit_last, i_out_ready,
        output o_bit_ready, o_enc_valid, o_enc_data, o_tbl_valid, o_tbl_entry
    );
endinterface

// File: rtl/conv_trellis_encoder.sv
// Runtime-configurable convolutional encoder (rate 1/2 or 1/3, K = 3..MAX_K)
// with zero-tail flush and a trellis-table generation mode.
module conv_trellis_encoder #(
    parameter int MAX_K      = 9,
    parameter int MAX_R      = 3,
    parameter int RADIX_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_mode_sel,
    input  logic                        i_code_rate,
    input  logic [3:0]                  i_constr_len,
    input  logic [MAX_R-1:0][MAX_K-1:0] i_gen_poly,
    conv_trellis_encoder_if.slave       bus,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int SW = MAX_K - 1;
    localparam int EW = RADIX_LOG2 + 2 * SW + RADIX_LOG2 * MAX_R;
    localparam logic [RADIX_LOG2-1:0] U_ONE = 1;
    localparam logic [SW-1:0]         S_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_FLUSH, S_TBL, S_DONE} fsm_t;

    fsm_t                        fsm_reg;
    logic                        rate_reg;
    logic [3:0]                  k_reg;
    logic [MAX_R-1:0][MAX_K-1:0] poly_reg;
    logic [SW-1:0]               state_reg;
    logic [3:0]                  flush_cnt_reg;
    logic [SW-1:0]               s_cnt_reg;
    logic [RADIX_LOG2-1:0]       u_cnt_reg;
    logic                        tbl_last_reg;
    logic                        enc_valid_reg;
    logic [MAX_R-1:0]            enc_data_reg;
    logic                        tbl_valid_reg;
    logic [EW-1:0]               tbl_entry_reg;
    logic                        done_reg;

    logic [MAX_K-1:0] tap_mask;
    logic [SW-1:0]    state_mask;
    logic [MAX_R-1:0] out_mask;

    function automatic logic [MAX_R-1:0] code_sym(
        input logic [SW-1:0]               st,
        input logic                        b,
        input logic [MAX_R-1:0][MAX_K-1:0] poly,
        input logic [MAX_K-1:0]            tmask,
        input logic [MAX_R-1:0]            omask
    );
        logic [MAX_K-1:0] sr;
        logic [MAX_R-1:0] sym;
        sr = {st, b} & tmask;
        for (int i = 0; i < MAX_R; i++) begin
            sym[i] = omask[i] & (^(poly[i] & sr));
        end
        return sym;
    endfunction

    function automatic logic [SW-1:0] next_st(
        input logic [SW-1:0] st,
        input logic          b,
        input logic [SW-1:0] smask
    );
        logic [MAX_K-1:0] sr;
        sr = {st, b};
        return sr[SW-1:0] & smask;
    endfunction

    generate
        for (genvar gi = 0; gi < MAX_K; gi++) begin : g_tap_mask
            assign tap_mask[gi] = (32'(gi) < {28'd0, k_reg});
        end
        for (genvar gi = 0; gi < SW; gi++) begin : g_state_mask
            assign state_mask[gi] = (32'(gi) + 32'd1 < {28'd0, k_reg});
        end
        for (genvar gi = 0; gi < MAX_R; gi++) begin : g_out_mask
            if (gi < 2) begin : g_always
                assign out_mask[gi] = 1'b1;
            end else if (gi == 2) begin : g_third
                assign out_mask[gi] = rate_reg;
            end else begin : g_never
                assign out_mask[gi] = 1'b0;
            end
        end
    endgenerate

    // Encoder datapath: flush steps feed zeros through the same shift register
    logic             enc_bit;
    logic [MAX_R-1:0] enc_sym;
    logic [SW-1:0]    enc_next;
    logic             enc_out_free;
    logic             bit_accept;

    assign enc_bit      = (fsm_reg == S_FLUSH) ? 1'b0 : bus.i_bit;
    assign enc_sym      = code_sym(state_reg, enc_bit, poly_reg, tap_mask, out_mask);
    assign enc_next     = next_st(state_reg, enc_bit, state_mask);
    assign enc_out_free = !enc_valid_reg || bus.i_out_ready;
    assign bit_accept   = bus.i_bit_valid && bus.o_bit_ready;

    // Table datapath: chain RADIX_LOG2 steps from s_cnt, step gi consumes u[gi]
    logic [SW-1:0]               tbl_st [0:RADIX_LOG2];
    logic [RADIX_LOG2*MAX_R-1:0] tbl_sym;
    logic [EW-1:0]               tbl_entry_comb;
    logic                        tbl_is_last;

    assign tbl_st[0] = s_cnt_reg;
    generate
        for (genvar gi = 0; gi < RADIX_LOG2; gi++) begin : g_tbl_step
            assign tbl_sym[gi*MAX_R +: MAX_R] =
                code_sym(tbl_st[gi], u_cnt_reg[gi], poly_reg, tap_mask, out_mask);
            assign tbl_st[gi+1] = next_st(tbl_st[gi], u_cnt_reg[gi], state_mask);
        end
    endgenerate

    assign tbl_entry_comb = {u_cnt_reg, s_cnt_reg, tbl_st[RADIX_LOG2], tbl_sym};
    assign tbl_is_last    = (s_cnt_reg == state_mask) && (&u_cnt_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg       <= S_IDLE;
            rate_reg      <= 1'b0;
            k_reg         <= 4'd0;
            poly_reg      <= '0;
            state_reg     <= '0;
            flush_cnt_reg <= 4'd0;
            s_cnt_reg     <= '0;
            u_cnt_reg     <= '0;
            tbl_last_reg  <= 1'b0;
            enc_valid_reg <= 1'b0;
            enc_data_reg  <= '0;
            tbl_valid_reg <= 1'b0;
            tbl_entry_reg <= '0;
            done_reg      <= 1'b0;
        end else if (fsm_reg != S_IDLE && i_abort) begin
            fsm_reg       <= S_IDLE;
            state_reg     <= '0;
            enc_valid_reg <= 1'b0;
            enc_data_reg  <= '0;
            tbl_valid_reg <= 1'b0;
            tbl_entry_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            case (fsm_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (i_start) begin
                        rate_reg     <= i_code_rate;
                        k_reg        <= i_constr_len;
                        poly_reg     <= i_gen_poly;
                        state_reg    <= '0;
                        s_cnt_reg    <= '0;
                        u_cnt_reg    <= '0;
                        tbl_last_reg <= 1'b0;
                        fsm_reg      <= i_mode_sel ? S_TBL : S_ENC;
                    end
                end
                S_ENC: begin
                    if (bit_accept) begin
                        enc_data_reg  <= enc_sym;
                        enc_valid_reg <= 1'b1;
                        state_reg     <= enc_next;
                        if (bus.i_bit_last) begin
                            fsm_reg       <= S_FLUSH;
                            flush_cnt_reg <= k_reg - 4'd1;
                        end
                    end else if (enc_valid_reg && bus.i_out_ready) begin
                        enc_valid_reg <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (enc_out_free) begin
                        if (flush_cnt_reg != 4'd0) begin
                            enc_data_reg  <= enc_sym;
                            enc_valid_reg <= 1'b1;
                            state_reg     <= enc_next;
                            flush_cnt_reg <= flush_cnt_reg - 4'd1;
                        end else begin
                            enc_valid_reg <= 1'b0;
                            fsm_reg       <= S_DONE;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                S_TBL: begin
                    if (tbl_valid_reg && bus.i_out_ready && tbl_last_reg) begin
                        tbl_valid_reg <= 1'b0;
                        fsm_reg       <= S_DONE;
                        done_reg      <= 1'b1;
                    end else if (!tbl_valid_reg || bus.i_out_ready) begin
                        tbl_entry_reg <= tbl_entry_comb;
                        tbl_valid_reg <= 1'b1;
                        tbl_last_reg  <= tbl_is_last;
                        u_cnt_reg     <= u_cnt_reg + U_ONE;
                        if (&u_cnt_reg) begin
                            s_cnt_reg <= s_cnt_reg + S_ONE;
                        end
                    end
                end
                S_DONE: begin
                    done_reg <= 1'b0;
                    fsm_reg  <= S_IDLE;
                end
                default: fsm_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.o_bit_ready = (fsm_reg == S_ENC) && enc_out_free;
    assign bus.o_enc_valid = enc_valid_reg;
    assign bus.o_enc_data  = enc_data_reg;
    assign bus.o_tbl_valid = tbl_valid_reg;
    assign bus.o_tbl_entry = tbl_entry_reg;
    assign o_busy          = (fsm_reg != S_IDLE);
    assign o_done          = done_reg;
endmodule

// File: tb/tb_conv_trellis_encoder.sv
// Directed bench for conv_trellis_encoder: K=3 encode/table vectors,
// backpressure, K=9 rate-1/3 stream against a model, abort and reset recovery.
module tb_conv_trellis_encoder;
    logic            clk;
    logic            rst;
    logic            i_start;
    logic            i_abort;
    logic            i_mode_sel;
    logic            i_code_rate;
    logic [3:0]      i_constr_len;
    logic [2:0][8:0] i_gen_poly;
    logic            o_busy;
    logic            o_done;

    conv_trellis_encoder_if #(.MAX_K(9), .MAX_R(3), .RADIX_LOG2(2)) bus ();

    conv_trellis_encoder #(.MAX_K(9), .MAX_R(3), .RADIX_LOG2(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_mode_sel   (i_mode_sel),
        .i_code_rate  (i_code_rate),
        .i_constr_len (i_constr_len),
        .i_gen_poly   (i_gen_poly),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    logic        bits_arr [0:127];
    logic [2:0]  got_q [$];
    logic [23:0] tbl_q [$];
    int          done_cnt;
    int          stall_bad;
    logic        timeout;

    // K=3, g0=111, g1=101, inputs 1,0,1,1 + two tail steps; bit0 = g0, bit1 = g1
    logic [2:0] k3_exp [0:5];

    task automatic load_k3_bits();
        bits_arr[0] = 1'b1; bits_arr[1] = 1'b0; bits_arr[2] = 1'b1; bits_arr[3] = 1'b1;
        k3_exp[0] = 3'b011; k3_exp[1] = 3'b001; k3_exp[2] = 3'b000;
        k3_exp[3] = 3'b010; k3_exp[4] = 3'b010; k3_exp[5] = 3'b011;
    endtask

    // Runs one encode job; records accepted codewords, done pulses and stall violations.
    task automatic run_enc(input int k, input logic rate, input logic [8:0] p0,
                           input logic [8:0] p1, input logic [8:0] p2, input int n,
                           input int stall_at, input int stall_len);
        int         idx;
        int         cyc;
        logic       stall;
        logic       prev_stall_valid;
        logic [2:0] prev_data;
        got_q.delete();
        done_cnt = 0; stall_bad = 0; timeout = 1'b0;
        idx = 0; cyc = 0; prev_stall_valid = 1'b0; prev_data = '0;
        @(negedge clk);
        i_mode_sel = 1'b0; i_code_rate = rate; i_constr_len = 4'(k);
        i_gen_poly[0] = p0; i_gen_poly[1] = p1; i_gen_poly[2] = p2;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        // configuration scrambled mid-job must have no effect
        i_mode_sel = 1'b1; i_code_rate = ~rate; i_constr_len = 4'd4; i_gen_poly = '1;
        forever begin
            stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            bus.i_out_ready = !stall;
            bus.i_bit_valid = (idx < n);
            bus.i_bit       = bits_arr[idx];
            bus.i_bit_last  = (idx == n - 1);
            #1;
            if (stall && bus.o_enc_valid) begin
                if (bus.o_bit_ready) stall_bad++;
                if (prev_stall_valid && bus.o_enc_data !== prev_data) stall_bad++;
            end
            prev_stall_valid = stall && bus.o_enc_valid;
            prev_data = bus.o_enc_data;
            if (bus.o_enc_valid && bus.i_out_ready) got_q.push_back(bus.o_enc_data);
            if (bus.o_bit_ready && bus.i_bit_valid) idx++;
            if (o_done) done_cnt++;
            else if (done_cnt > 0) break;
            cyc++;
            if (cyc > 2000) begin timeout = 1'b1; break; end
            @(negedge clk);
        end
        bus.i_bit_valid = 1'b0; bus.i_bit_last = 1'b0; bus.i_out_ready = 1'b1;
    endtask

    // Runs one K=3 table job; ready_pat 1 throttles the output every third cycle.
    task automatic run_tbl(input int ready_pat);
        int cyc;
        tbl_q.delete();
        done_cnt = 0; stall_bad = 0; timeout = 1'b0; cyc = 0;
        @(negedge clk);
        i_mode_sel = 1'b1; i_code_rate = 1'b0; i_constr_len = 4'd3;
        i_gen_poly[0] = 9'b111; i_gen_poly[1] = 9'b101; i_gen_poly[2] = 9'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_mode_sel = 1'b0; i_constr_len = 4'd9; i_gen_poly = '1;
        forever begin
            bus.i_out_ready = (ready_pat == 0) || (cyc % 3 != 1);
            bus.i_bit_valid = 1'b1;
            #1;
            if (bus.o_bit_ready) stall_bad++;
            if (bus.o_tbl_valid && bus.i_out_ready) tbl_q.push_back(bus.o_tbl_entry);
            if (o_done) done_cnt++;
            else if (done_cnt > 0) break;
            cyc++;
            if (cyc > 2000) begin timeout = 1'b1; break; end
            @(negedge clk);
        end
        bus.i_bit_valid = 1'b0; bus.i_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_mode_sel = 1'b0; i_code_rate = 1'b0;
        i_constr_len = 4'd3; i_gen_poly = '0;
        bus.i_bit_valid = 1'b0; bus.i_bit = 1'b0; bus.i_bit_last = 1'b0; bus.i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({o_busy, o_done, bus.o_enc_valid, bus.o_tbl_valid, bus.o_bit_ready} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b want=00000",
                {o_busy, o_done, bus.o_enc_valid, bus.o_tbl_valid, bus.o_bit_ready});
        end
        n_cmp++;
        if (bus.o_enc_data !== 3'd0 || bus.o_tbl_entry !== 24'd0) begin
            n_bad++; $display("FAIL reset_data got=%h/%h want=0/0", bus.o_enc_data, bus.o_tbl_entry);
        end
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (o_busy !== 1'b0 || bus.o_bit_ready !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset busy=%b ready=%b want=0/0", o_busy, bus.o_bit_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_encode_k3();
        load_k3_bits();
        run_enc(3, 1'b0, 9'b111, 9'b101, 9'b0, 4, 1000, 0);
        n_cmp++;
        if (timeout !== 1'b0 || got_q.size() != 6) begin
            n_bad++; $display("FAIL enc_k3_count got=%0d timeout=%b want=6", got_q.size(), timeout);
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== k3_exp[i]) begin
                n_bad++; $display("FAIL enc_k3_word[%0d] got=%b want=%b", i, got_q[i], k3_exp[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL enc_k3_done pulses=%0d busy=%b want=1/0", done_cnt, o_busy);
        end
        $display("test_encode_k3 words=%0d", got_q.size());
    endtask

    task automatic test_table_k3();
        run_tbl(1);
        n_cmp++;
        if (timeout !== 1'b0 || tbl_q.size() != 16 || done_cnt != 1) begin
            n_bad++; $display("FAIL tbl_count got=%0d done=%0d want=16/1", tbl_q.size(), done_cnt);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++; $display("FAIL tbl_bit_ready got=%0d want=0", stall_bad);
        end
        for (int i = 0; i < tbl_q.size(); i++) begin
            n_cmp++;
            if (tbl_q[i][23:22] !== 2'(i % 4) || tbl_q[i][21:14] !== 8'(i / 4)) begin
                n_bad++; $display("FAIL tbl_index[%0d] got=%h want u=%0d s=%0d", i, tbl_q[i], i % 4, i / 4);
            end
        end
        if (tbl_q.size() == 16) begin
            n_cmp++;
            if (tbl_q[0] !== 24'h000000) begin
                n_bad++; $display("FAIL tbl_s0u0 got=%h want=000000", tbl_q[0]);
            end
            n_cmp++;
            if (tbl_q[3] !== {2'b11, 8'd0, 8'd3, 6'b010011}) begin
                n_bad++; $display("FAIL tbl_s0u3 got=%h want=%h", tbl_q[3], {2'b11, 8'd0, 8'd3, 6'b010011});
            end
            n_cmp++;
            if (tbl_q[9] !== {2'b01, 8'd2, 8'd2, 6'b001000}) begin
                n_bad++; $display("FAIL tbl_s2u1 got=%h want=%h", tbl_q[9], {2'b01, 8'd2, 8'd2, 6'b001000});
            end
            n_cmp++;
            if (tbl_q[15] !== {2'b11, 8'd3, 8'd3, 6'b001001}) begin
                n_bad++; $display("FAIL tbl_s3u3 got=%h want=%h", tbl_q[15], {2'b11, 8'd3, 8'd3, 6'b001001});
            end
        end
        $display("test_table_k3 entries=%0d", tbl_q.size());
    endtask

    task automatic test_backpressure();
        load_k3_bits();
        run_enc(3, 1'b0, 9'b111, 9'b101, 9'b0, 4, 2, 3);
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++; $display("FAIL bp_stall_violations got=%0d want=0", stall_bad);
        end
        n_cmp++;
        if (timeout !== 1'b0 || got_q.size() != 6) begin
            n_bad++; $display("FAIL bp_count got=%0d want=6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== k3_exp[i]) begin
                n_bad++; $display("FAIL bp_word[%0d] got=%b want=%b", i, got_q[i], k3_exp[i]);
            end
        end
        $display("test_backpressure words=%0d", got_q.size());
    endtask

    task automatic test_k9_random();
        logic [8:0] p [0:2];
        logic [8:0] hist;
        logic [2:0] exp_q [$];
        logic [2:0] w;
        p[0] = 9'o557; p[1] = 9'o663; p[2] = 9'o711;
        hist = '0;
        for (int i = 0; i < 108; i++) begin
            if (i < 100) bits_arr[i] = 1'($urandom_range(0, 1));
            hist = {hist[7:0], (i < 100) ? bits_arr[i] : 1'b0};
            for (int j = 0; j < 3; j++) w[j] = ^(p[j] & hist);
            exp_q.push_back(w);
        end
        run_enc(9, 1'b1, p[0], p[1], p[2], 100, 37, 4);
        n_cmp++;
        if (timeout !== 1'b0 || got_q.size() != 108 || done_cnt != 1) begin
            n_bad++; $display("FAIL k9_count got=%0d done=%0d want=108/1", got_q.size(), done_cnt);
        end
        for (int i = 0; i < 108 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL k9_word[%0d] got=%b want=%b", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_k9_random words=%0d", got_q.size());
    endtask

    task automatic test_abort_flush();
        int seen;
        @(negedge clk);
        i_mode_sel = 1'b0; i_code_rate = 1'b0; i_constr_len = 4'd5;
        i_gen_poly[0] = 9'b10011; i_gen_poly[1] = 9'b11101; i_gen_poly[2] = 9'b0;
        i_start = 1'b1; bus.i_out_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        bus.i_bit_valid = 1'b1; bus.i_bit = 1'b1; bus.i_bit_last = 1'b0;
        @(negedge clk);
        bus.i_bit_last = 1'b1;
        @(negedge clk);
        bus.i_bit_valid = 1'b0; bus.i_bit_last = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (o_busy !== 1'b1 || bus.o_enc_valid !== 1'b1) begin
            n_bad++; $display("FAIL abort_in_flush busy=%b valid=%b want=1/1", o_busy, bus.o_enc_valid);
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0; #1;
        n_cmp++;
        if ({o_busy, bus.o_enc_valid, bus.o_tbl_valid, bus.o_enc_data} !== 6'b0) begin
            n_bad++; $display("FAIL abort_outputs got=%b want=000000",
                {o_busy, bus.o_enc_valid, bus.o_tbl_valid, bus.o_enc_data});
        end
        seen = 0;
        repeat (6) begin
            if (o_done) seen++;
            @(negedge clk); #1;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL abort_no_done got=%0d want=0", seen);
        end
        load_k3_bits();
        run_enc(3, 1'b0, 9'b111, 9'b101, 9'b0, 4, 1000, 0);
        n_cmp++;
        if (got_q.size() != 6 || done_cnt != 1) begin
            n_bad++; $display("FAIL abort_next_count got=%0d done=%0d want=6/1", got_q.size(), done_cnt);
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== k3_exp[i]) begin
                n_bad++; $display("FAIL abort_next_word[%0d] got=%b want=%b", i, got_q[i], k3_exp[i]);
            end
        end
        $display("test_abort_flush next_words=%0d", got_q.size());
    endtask

    task automatic test_reset_mid_tbl();
        @(negedge clk);
        i_mode_sel = 1'b1; i_code_rate = 1'b0; i_constr_len = 4'd3;
        i_gen_poly[0] = 9'b111; i_gen_poly[1] = 9'b101; i_gen_poly[2] = 9'b0;
        i_start = 1'b1; bus.i_out_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_busy, o_done, bus.o_tbl_valid, bus.o_enc_valid, bus.o_bit_ready} !== 5'b0
            || bus.o_tbl_entry !== 24'd0) begin
            n_bad++; $display("FAIL rst_mid_tbl flags=%b entry=%h want=0/0",
                {o_busy, o_done, bus.o_tbl_valid, bus.o_enc_valid, bus.o_bit_ready}, bus.o_tbl_entry);
        end
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        run_tbl(0);
        n_cmp++;
        if (timeout !== 1'b0 || tbl_q.size() != 16 || done_cnt != 1) begin
            n_bad++; $display("FAIL rst_next_tbl_count got=%0d done=%0d want=16/1", tbl_q.size(), done_cnt);
        end
        if (tbl_q.size() == 16) begin
            n_cmp++;
            if (tbl_q[3] !== {2'b11, 8'd0, 8'd3, 6'b010011}) begin
                n_bad++; $display("FAIL rst_next_tbl_s0u3 got=%h want=%h", tbl_q[3], {2'b11, 8'd0, 8'd3, 6'b010011});
            end
        end
        $display("test_reset_mid_tbl entries=%0d", tbl_q.size());
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_encode_k3();
        test_table_k3();
        test_backpressure();
        test_k9_random();
        test_abort_flush();
        test_reset_mid_tbl();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
